serial_adder8: RTL and testbench

SERIAL_ADDER8 -- requirements
Module: serial_adder8

---
 rtl/alu_pkg.sv | 12 +
 rtl/serial_adder8_fa.sv | 13 +
 rtl/serial_adder8.sv | 123 ++++++++++++
 tb/tb_serial_adder8.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the serial adder's FSM state encoding and default operand width.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder8_fa.sv
// FA: the team's 1-bit full adder cell, purely combinational.
module FA (
  output logic Cout,
  output logic Sum,
  input  logic A,
  input  logic B,
  input  logic Cin
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder8.sv
// serial_adder8: bit-serial adder computing {cout,sum} = a + b + cin over WIDTH cycles,
// one bit per clock through a single full-adder cell.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into a - b (B inverted, carry forced to 1).
module serial_adder8
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Operand B and the initial carry as they should be captured on an accepted start.
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load     = b;
    carry_load = cin;
    if (sub) begin
      b_load     = ~b;
      carry_load = 1'b1;
    end
  end
`else
  always_comb begin
    b_load     = b;
    carry_load = cin;
  end
`endif

  // The only arithmetic in the datapath: one full-adder cell fed from the shift register LSBs.
  FA u_fa (
    .Cout (fa_cout),
    .Sum  (fa_sum),
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry)
  );

  // Result register shifted right with the new sum bit entering at the MSB.
  always_comb begin
    res_next            = res_sr >> 1;
    res_next[WIDTH-1]   = fa_sum;
  end

  // FSM with datapath and registered outputs; sum/cout change only when entering DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= carry_load;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res_sr <= res_next;
          carry  <= fa_cout;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          count  <= count + CW'(1);
          if (count == LAST_BIT) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= res_next;
            cout  <= fa_cout;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder8.sv
// tb_serial_adder8: table-driven and scoreboard checks for serial_adder8.
// Define SERIAL_ADDER_SUB_EN to also exercise the subtract option.
module tb_serial_adder8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_sum;
  logic       last_cout;

  serial_adder8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one start pulse (accepted at the following rising edge) and optionally queue its result.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                               input bit push, input logic [7:0] es, input logic ec);
    exp_t e;
    @(negedge clk);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    if (push) begin
      e.sum  = es;
      e.cout = ec;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done, check the latency, then pop and compare the scoreboard entry.
  task automatic checkOutput(input string name, input int exp_lat);
    int   lat;
    bit   got;
    exp_t e;
    lat = 0;
    got = 1'b0;
    while (lat < 20 && !got) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s done_timeout actual=none required=done", name);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    check({name, " latency"}, lat, exp_lat);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard actual=empty required=entry", name);
      return;
    end
    e = sb_q.pop_front();
    check({name, " sum"}, sum, e.sum);
    check({name, " cout"}, cout, e.cout);
    last_sum  = e.sum;
    last_cout = e.cout;
  endtask

  initial begin
    vec_t vecs[10];
    logic [8:0] model;
    logic [7:0] ra, rb;
    logic       rc;
    int         seen;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h35, 8'h4A, 1'b1, 8'h80, 1'b0};
    vecs[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    vecs[5] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0};
    vecs[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[9] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};

    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    last_sum  = 8'h00;
    last_cout = 1'b0;

    // Reset with start asserted: start must be discarded.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset sum", sum, 8'h00);
    check("reset cout", cout, 1'b0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("post-reset busy", busy, 1'b0);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, vecs[i].exp_sum, vecs[i].exp_cout);
      checkOutput($sformatf("vec%0d", i), 9);
    end

    // Random vectors against a plain arithmetic model.
    for (int i = 0; i < 6; i++) begin
      ra    = 8'($urandom_range(0, 255));
      rb    = 8'($urandom_range(0, 255));
      rc    = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      applyStimulus(ra, rb, rc, 1'b1, model[7:0], model[8]);
      checkOutput($sformatf("rand%0d", i), 9);
    end

    // Timing: busy during RUN, outputs frozen, start while busy ignored.
    applyStimulus(8'h35, 8'h4A, 1'b1, 1'b1, 8'h80, 1'b0);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      check($sformatf("run%0d busy", cyc), busy, 1'b1);
      check($sformatf("run%0d done", cyc), done, 1'b0);
      check($sformatf("run%0d sum held", cyc), sum, last_sum);
      if (cyc == 3) begin
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b0;
        start = 1'b1;
      end
      if (cyc == 4) start = 1'b0;
    end
    checkOutput("timing", 1);
    @(negedge clk);
    check("timing after done", done, 1'b0);
    check("timing after busy", busy, 1'b0);
    check("timing sum kept", sum, 8'h80);

    // Reset in the middle of RUN aborts without a done pulse.
    applyStimulus(8'hA5, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort sum", sum, 8'h00);
    check("abort cout", cout, 1'b0);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("abort no done", seen, 0);

    // Back-to-back: start held through DONE restarts immediately.
    @(negedge clk);
    a     = 8'h10;
    b     = 8'h20;
    cin   = 1'b0;
    start = 1'b1;
    sb_q.push_back('{8'h30, 1'b0});
    sb_q.push_back('{8'h30, 1'b0});
    @(posedge clk);
    checkOutput("b2b first", 9);
    @(negedge clk);
    check("b2b gap done", done, 1'b0);
    check("b2b gap busy", busy, 1'b1);
    start = 1'b0;
    checkOutput("b2b second", 8);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract option.
    sub = 1'b1;
    applyStimulus(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    checkOutput("sub 5-7", 9);
    applyStimulus(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1);
    checkOutput("sub 7-5", 9);
    sub = 1'b0;
    applyStimulus(8'h07, 8'h05, 1'b1, 1'b1, 8'h0D, 1'b0);
    checkOutput("sub0 add", 9);
`endif

    check("scoreboard drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
